// File: rtl/instruction_fetch.sv
// Fetch stage: PC register plus IF/ID pipeline register, with decode stall and execute redirect.
// The IF/ID slot is VALID or BUBBLE, encoded directly by if_id_valid.
module instruction_fetch #(
  parameter int unsigned         dataWidth = 32,
  parameter int unsigned         addrSize  = 32,
  parameter logic [addrSize-1:0] resetPC   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [addrSize-1:0]  imem_addr,
  input  logic [dataWidth-1:0] imem_instr,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [addrSize-1:0]  redirect_target,
  output logic [addrSize-1:0]  pc,
  output logic [dataWidth-1:0] if_id_instr,
  output logic [addrSize-1:0]  if_id_pc_plus4,
  output logic                 if_id_valid,
  output logic                 fetch_misaligned,
  output logic [31:0]          fetch_count
);

  localparam logic [addrSize-1:0] PcStep = addrSize'(4);

  logic [addrSize-1:0]  pc_q, pc_d;
  logic [dataWidth-1:0] instr_q, instr_d;
  logic [addrSize-1:0]  pc_plus4_q, pc_plus4_d;
  logic                 valid_q, valid_d;
  logic                 misaligned_q, misaligned_d;
  logic [31:0]          count_q, count_d;
  logic [addrSize-1:0]  pc_plus4;

  assign pc_plus4 = pc_q + PcStep;

  always_comb begin
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_plus4_d   = pc_plus4_q;
    valid_d      = valid_q;
    misaligned_d = 1'b0;
    count_d      = count_q;
    if (redirect_valid) begin
      // Redirect wins over stall; the wrong-path slot becomes a bubble, data fields are kept.
      pc_d         = {redirect_target[addrSize-1:2], 2'b00};
      valid_d      = 1'b0;
      misaligned_d = |redirect_target[1:0];
    end else if (!stall) begin
      pc_d       = pc_plus4;
      instr_d    = imem_instr;
      pc_plus4_d = pc_plus4;
      valid_d    = 1'b1;
      count_d    = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= resetPC;
      instr_q      <= '0;
      pc_plus4_q   <= '0;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
      count_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc_plus4_q   <= pc_plus4_d;
      valid_q      <= valid_d;
      misaligned_q <= misaligned_d;
      count_q      <= count_d;
    end
  end

  assign imem_addr        = pc_q;
  assign pc               = pc_q;
  assign if_id_instr      = instr_q;
  assign if_id_pc_plus4   = pc_plus4_q;
  assign if_id_valid      = valid_q;
  assign fetch_misaligned = misaligned_q;
  assign fetch_count      = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed steps push hand-computed expectations,
// a monitor pops and compares after each rising edge. Unit 1 is a wrap-around instance.
module tb_instruction_fetch;

  typedef struct {
    bit          unit;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
    logic        valid;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        rv = 1'b0;
  logic [31:0] tgt = '0;

  logic [31:0] a_addr, a_imem, a_pc, a_instr, a_p4, a_cnt;
  logic        a_valid, a_mis;
  logic [31:0] b_addr, b_imem, b_pc, b_instr, b_p4, b_cnt;
  logic        b_valid, b_mis;

  int n_chk  = 0;
  int n_pass = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign a_imem = a_addr ^ 32'hA5A5_0000;
  assign b_imem = b_addr ^ 32'hA5A5_0000;

  instruction_fetch #(.dataWidth(32), .addrSize(32), .resetPC(32'h0)) dut_a (
    .clk(clk), .rst(rst), .imem_addr(a_addr), .imem_instr(a_imem), .stall(stall),
    .redirect_valid(rv), .redirect_target(tgt), .pc(a_pc), .if_id_instr(a_instr),
    .if_id_pc_plus4(a_p4), .if_id_valid(a_valid), .fetch_misaligned(a_mis),
    .fetch_count(a_cnt)
  );

  instruction_fetch #(.dataWidth(32), .addrSize(32), .resetPC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst), .imem_addr(b_addr), .imem_instr(b_imem), .stall(stall),
    .redirect_valid(rv), .redirect_target(tgt), .pc(b_pc), .if_id_instr(b_instr),
    .if_id_pc_plus4(b_p4), .if_id_valid(b_valid), .fetch_misaligned(b_mis),
    .fetch_count(b_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares every expectation queued for the edge just taken.
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (!e.unit) begin
        chk("a.pc", a_pc, e.pc);
        chk("a.imem_addr", a_addr, e.pc);
        chk("a.if_id_instr", a_instr, e.instr);
        chk("a.if_id_pc_plus4", a_p4, e.p4);
        chk("a.if_id_valid", {31'd0, a_valid}, {31'd0, e.valid});
        chk("a.fetch_misaligned", {31'd0, a_mis}, {31'd0, e.mis});
        chk("a.fetch_count", a_cnt, e.cnt);
      end else begin
        chk("b.pc", b_pc, e.pc);
        chk("b.imem_addr", b_addr, e.pc);
        chk("b.if_id_instr", b_instr, e.instr);
        chk("b.if_id_pc_plus4", b_p4, e.p4);
        chk("b.if_id_valid", {31'd0, b_valid}, {31'd0, e.valid});
        chk("b.fetch_misaligned", {31'd0, b_mis}, {31'd0, e.mis});
        chk("b.fetch_count", b_cnt, e.cnt);
      end
    end
  end

  // Drive one cycle of inputs and queue what the selected unit must show after the edge.
  task automatic step(input bit r, input bit s, input bit v, input logic [31:0] t,
                      input bit unit, input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_p4, input logic e_valid, input logic e_mis,
                      input logic [31:0] e_cnt);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; rv = v; tgt = t;
    e.unit = unit; e.pc = e_pc; e.instr = e_instr; e.p4 = e_p4;
    e.valid = e_valid; e.mis = e_mis; e.cnt = e_cnt;
    sb.push_back(e);
  endtask

  task automatic push_b_reset();
    exp_t e;
    e.unit = 1'b1; e.pc = 32'hFFFF_FFFC; e.instr = '0; e.p4 = '0;
    e.valid = 1'b0; e.mis = 1'b0; e.cnt = '0;
    sb.push_back(e);
  endtask

  initial begin
    // Reset both instances.
    step(1, 0, 0, 0,  0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    push_b_reset();
    // Wrap-around instance: fetch at 0xFFFFFFFC, next PC wraps to 0.
    step(0, 0, 0, 0,  1, 32'h0, 32'h5A5A_FFFC, 32'h0, 1, 0, 1);
    step(0, 0, 0, 0,  1, 32'h4, 32'hA5A5_0000, 32'h4, 1, 0, 2);
    // Reset, then run from 0.
    step(1, 0, 0, 0,  0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step(0, 0, 0, 0,  0, 32'h4, 32'hA5A5_0000, 32'h4, 1, 0, 1);
    step(0, 0, 0, 0,  0, 32'h8, 32'hA5A5_0004, 32'h8, 1, 0, 2);
    // Stall three cycles at pc=8.
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 0,  0, 32'h8, 32'hA5A5_0004, 32'h8, 1, 0, 2);
    step(0, 0, 0, 0,  0, 32'hC, 32'hA5A5_0008, 32'hC, 1, 0, 3);
    step(0, 0, 0, 0,  0, 32'h10, 32'hA5A5_000C, 32'h10, 1, 0, 4);
    // Redirect during stall.
    step(0, 1, 1, 32'h100,  0, 32'h100, 32'hA5A5_000C, 32'h10, 0, 0, 4);
    step(0, 0, 0, 0,  0, 32'h104, 32'hA5A5_0100, 32'h104, 1, 0, 5);
    // Misaligned redirect: one-cycle pulse.
    step(0, 0, 1, 32'h203,  0, 32'h200, 32'hA5A5_0100, 32'h104, 0, 1, 5);
    step(0, 0, 0, 0,  0, 32'h204, 32'hA5A5_0200, 32'h204, 1, 0, 6);
    step(0, 0, 0, 0,  0, 32'h208, 32'hA5A5_0204, 32'h208, 1, 0, 7);
    // Aligned redirect followed by a stall keeps the bubble.
    step(0, 0, 1, 32'h10,  0, 32'h10, 32'hA5A5_0204, 32'h208, 0, 0, 7);
    step(0, 1, 0, 0,  0, 32'h10, 32'hA5A5_0204, 32'h208, 0, 0, 7);
    step(0, 0, 0, 0,  0, 32'h14, 32'hA5A5_0010, 32'h14, 1, 0, 8);
    // Preload fetch_count near max during a stall cycle, then let it wrap.
    @(negedge clk);
    rst = 0; stall = 1; rv = 0;
    force dut_a.count_q = 32'hFFFF_FFFE;
    @(posedge clk);
    #2 release dut_a.count_q;
    step(0, 0, 0, 0,  0, 32'h18, 32'hA5A5_0014, 32'h18, 1, 0, 32'hFFFF_FFFF);
    step(0, 0, 0, 0,  0, 32'h1C, 32'hA5A5_0018, 32'h1C, 1, 0, 32'h0);
    // Mid-stream reset with stall and redirect both asserted.
    step(1, 1, 1, 32'h300,  0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step(0, 0, 0, 0,  0, 32'h4, 32'hA5A5_0000, 32'h4, 1, 0, 1);
    // Bounded drain of the scoreboard.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the single-issue MIPS pipeline. Holds the program counter, drives the word address into the combinational `instructionMemory`, and captures the returned instruction together with PC+4 into the IF/ID pipeline register for the decoder. Supports a hazard stall from decode and a branch/jump redirect from execute, which flushes the wrong-path instruction.

## Interface
- `dataWidth`, 32, instruction width; must equal `instructionMemory.dataWidth`.
- `addrSize`, 32, PC / address width; must equal `instructionMemory.addrSize`.
- `resetPC`, 0, PC value loaded on reset.

Ports, one per line: name, direction, width, meaning.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  addrSize  address to `instructionMemory.addr`; equals `pc`.
- `imem_instr`  in  dataWidth  instruction returned combinationally from `instructionMemory.instruction`.
- `stall`  in  1  decode hazard; hold PC and IF/ID.
- `redirect_valid`  in  1  taken branch or jump from execute.
- `redirect_target`  in  addrSize  new PC when `redirect_valid` is 1.
- `pc`  out  addrSize  current fetch PC.
- `if_id_instr`  out  dataWidth  registered instruction.
- `if_id_pc_plus4`  out  addrSize  registered PC+4 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction; 0 means bubble.
- `fetch_misaligned`  out  1  one-cycle pulse when a redirect target had nonzero `[1:0]`.
- `fetch_count`  out  32  number of instructions captured into IF/ID.

## Operation
- Memory is combinational. `imem_addr = pc`, and `imem_instr` is sampled in the same cycle.
- Each rising edge updates state per this priority list (highest first):
  1. `rst`: `pc <= resetPC`. `if_id_instr`, `if_id_pc_plus4` and `fetch_count` clear to 0. `if_id_valid <= 0`, `fetch_misaligned <= 0`.
  2. `redirect_valid`: `pc <= {redirect_target[addrSize-1:2], 2'b00}`. `if_id_valid <= 0`, which flushes the wrong-path slot. `if_id_instr` and `if_id_pc_plus4` are held. `fetch_misaligned <= |redirect_target[1:0]`. `fetch_count` is held. Redirect overrides `stall`.
  3. `stall`: PC and all IF/ID fields hold. `fetch_misaligned <= 0`.
  4. Normal: `pc <= pc + 4`. `if_id_instr <= imem_instr`, `if_id_pc_plus4 <= pc + 4`, `if_id_valid <= 1`. `fetch_count <= fetch_count + 1`. `fetch_misaligned <= 0`.
- PC arithmetic is modulo 2^addrSize. From `pc = 2^addrSize - 4`, the next PC is 0 and `if_id_pc_plus4` captures 0.
- `fetch_count` wraps from 0xFFFFFFFF to 0 without saturation.
- The PC register and the IF/ID register are each a single register, with no buffering between them. The stage is a two-state machine per slot (VALID / BUBBLE), encoded by `if_id_valid`.
- Reset asserted mid-stream takes effect on the next edge, whatever `stall` and `redirect_valid` are doing.

## Timing
- Reset values: `pc = resetPC`, `imem_addr = resetPC`, `if_id_valid = 0`, `if_id_instr = 0`, `if_id_pc_plus4 = 0`, `fetch_misaligned = 0`, `fetch_count = 0`.
- Fetch latency: an instruction at `pc` in cycle N appears on `if_id_instr` in cycle N+1.
- Redirect latency: with `redirect_valid` in cycle N, `if_id_valid = 0` in cycle N+1 and `pc = target` in cycle N+1. The target instruction is valid in IF/ID in cycle N+2, unless stalled. This gives exactly one bubble per redirect.
- Stall: held for k cycles, PC and IF/ID are frozen for k cycles. Deassertion resumes fetch on the next edge. No instruction is lost or duplicated.
- `fetch_misaligned` is high for exactly the one cycle after the redirect edge.
- All outputs are registered except `imem_addr`, which is a wire from `pc`.

## Test plan
- Reset then run. Memory model returns `addr ^ 0xA5A50000`. After `rst` falls, cycles 1–3 show `if_id_instr` = 0xA5A50000, 0xA5A50004, 0xA5A50008, with `if_id_pc_plus4` = 4, 8, 12, `if_id_valid = 1`, and `fetch_count = 3`.
- Stall. Assert `stall` for 3 cycles while `pc = 8`. `pc` stays 8 and `if_id_pc_plus4` stays 8 throughout. After release, the next capture is the instruction at 8, with no skip and no repeat.
- Redirect during stall. Set `stall = 1` and `redirect_valid = 1` with target 0x100. Next cycle: `pc = 0x100`, `if_id_valid = 0`, `fetch_count` unchanged. Following cycle (no stall): IF/ID holds the 0x100 instruction with `if_id_pc_plus4 = 0x104`.
- Misaligned redirect. Redirect to target 0x203. Next cycle: `pc = 0x200`, and `fetch_misaligned` is 1 for one cycle, then returns to 0.
- Wrap-around. With `resetPC = 0xFFFFFFFC`, after one capture `if_id_pc_plus4 = 0` and `pc = 0`. Separately, force `fetch_count` near max and check that it wraps to 0.
- Mid-stream reset. Assert `rst` while `stall = 1` and `redirect_valid = 1`. The next edge produces all reset values listed above.
